// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode fields, forwarding taps from EX/MEM and MEM/WB,
// and the operand/control bundle handed to the ALU and later stages.
interface id_ex_stage_if #(
    parameter int NBITS  = 32,
    parameter int RNBITS = 5,
    parameter int NB_OP  = 4,
    parameter int NB_IMM = 16
);
    // hazard control and decode slot
    logic              i_stall;
    logic              i_flush;
    logic              i_valid;
    logic [NBITS-1:0]  i_rs_data;
    logic [NBITS-1:0]  i_rt_data;
    logic [NB_IMM-1:0] i_imm;
    logic              i_sign_ext;
    logic              i_alu_src;
    logic [RNBITS-1:0] i_rs_addr;
    logic [RNBITS-1:0] i_rt_addr;
    logic [RNBITS-1:0] i_rd_addr;
    logic [RNBITS-1:0] i_shamt;
    logic              i_ushamt;
    logic [NB_OP-1:0]  i_operation;
    logic              i_reg_write;
    logic              i_mem_read;
    logic              i_mem_write;
    logic              i_mem_to_reg;
    // forwarding taps
    logic              i_exmem_reg_write;
    logic [RNBITS-1:0] i_exmem_rd;
    logic [NBITS-1:0]  i_exmem_result;
    logic              i_memwb_reg_write;
    logic [RNBITS-1:0] i_memwb_rd;
    logic [NBITS-1:0]  i_memwb_data;
    // EX stage outputs
    logic              o_valid;
    logic [NBITS-1:0]  o_data_1;
    logic [NBITS-1:0]  o_data_2;
    logic [NBITS-1:0]  o_store_data;
    logic [RNBITS-1:0] o_shamt;
    logic              o_ushamt;
    logic [NB_OP-1:0]  o_operation;
    logic [RNBITS-1:0] o_rd;
    logic              o_reg_write;
    logic              o_mem_read;
    logic              o_mem_write;
    logic              o_mem_to_reg;

    // driver side (decode / hazard unit / later stages)
    modport master (
        output i_stall, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_sign_ext,
               i_alu_src, i_rs_addr, i_rt_addr, i_rd_addr, i_shamt, i_ushamt,
               i_operation, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
               i_exmem_reg_write, i_exmem_rd, i_exmem_result,
               i_memwb_reg_write, i_memwb_rd, i_memwb_data,
        input  o_valid, o_data_1, o_data_2, o_store_data, o_shamt, o_ushamt,
               o_operation, o_rd, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg
    );

    // the stage itself
    modport slave (
        input  i_stall, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_sign_ext,
               i_alu_src, i_rs_addr, i_rt_addr, i_rd_addr, i_shamt, i_ushamt,
               i_operation, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
               i_exmem_reg_write, i_exmem_rd, i_exmem_result,
               i_memwb_reg_write, i_memwb_rd, i_memwb_data,
        output o_valid, o_data_1, o_data_2, o_store_data, o_shamt, o_ushamt,
               o_operation, o_rd, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding and operand selection.
// Registers decoded fields once per clock (flush > stall > load), then
// resolves rs/rt against EX/MEM and MEM/WB results combinationally.
module id_ex_stage #(
    parameter int NBITS  = 32,
    parameter int RNBITS = 5,
    parameter int NB_OP  = 4,
    parameter int NB_IMM = 16
) (
    input logic          i_clk,
    input logic          i_rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(2);

    logic              valid_q;
    logic [NBITS-1:0]  rs_data_q, rt_data_q, imm_q;
    logic              alu_src_q;
    logic [RNBITS-1:0] rs_addr_q, rt_addr_q, rd_q, shamt_q;
    logic              ushamt_q;
    logic [NB_OP-1:0]  op_q;
    logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;

    logic [NBITS-1:0]  imm_ext;
    logic [NBITS-1:0]  rs_fwd, rt_fwd;

    // extend before registering so EX only sees a full-width immediate
    always_comb begin
        imm_ext = bus.i_sign_ext ? {{(NBITS-NB_IMM){bus.i_imm[NB_IMM-1]}}, bus.i_imm}
                                 : {{(NBITS-NB_IMM){1'b0}}, bus.i_imm};
    end

    // stage register: flush inserts an ADD bubble, stall holds, else load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_q         <= '0;
            shamt_q      <= '0;
            ushamt_q     <= 1'b0;
            op_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (bus.i_flush) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_q         <= '0;
            shamt_q      <= '0;
            ushamt_q     <= 1'b0;
            op_q         <= OP_ADD;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!bus.i_stall) begin
            valid_q      <= bus.i_valid;
            rs_data_q    <= bus.i_rs_data;
            rt_data_q    <= bus.i_rt_data;
            imm_q        <= imm_ext;
            alu_src_q    <= bus.i_alu_src;
            rs_addr_q    <= bus.i_rs_addr;
            rt_addr_q    <= bus.i_rt_addr;
            rd_q         <= bus.i_rd_addr;
            shamt_q      <= bus.i_shamt;
            ushamt_q     <= bus.i_ushamt;
            op_q         <= bus.i_operation;
            reg_write_q  <= bus.i_reg_write;
            mem_read_q   <= bus.i_mem_read;
            mem_write_q  <= bus.i_mem_write;
            mem_to_reg_q <= bus.i_mem_to_reg;
        end
    end

    // forwarding: nearest producer wins, $0 is never forwarded
    always_comb begin
        rs_fwd = rs_data_q;
        if (bus.i_exmem_reg_write && bus.i_exmem_rd != '0 && bus.i_exmem_rd == rs_addr_q)
            rs_fwd = bus.i_exmem_result;
        else if (bus.i_memwb_reg_write && bus.i_memwb_rd != '0 && bus.i_memwb_rd == rs_addr_q)
            rs_fwd = bus.i_memwb_data;

        rt_fwd = rt_data_q;
        if (bus.i_exmem_reg_write && bus.i_exmem_rd != '0 && bus.i_exmem_rd == rt_addr_q)
            rt_fwd = bus.i_exmem_result;
        else if (bus.i_memwb_reg_write && bus.i_memwb_rd != '0 && bus.i_memwb_rd == rt_addr_q)
            rt_fwd = bus.i_memwb_data;
    end

    // operand mux and pass-through fields toward the ALU and later stages
    always_comb begin
        bus.o_valid      = valid_q;
        bus.o_data_1     = rs_fwd;
        bus.o_data_2     = alu_src_q ? imm_q : rt_fwd;
        bus.o_store_data = rt_fwd;
        bus.o_shamt      = shamt_q;
        bus.o_ushamt     = ushamt_q;
        bus.o_operation  = op_q;
        bus.o_rd         = rd_q;
        bus.o_reg_write  = reg_write_q;
        bus.o_mem_read   = mem_read_q;
        bus.o_mem_write  = mem_write_q;
        bus.o_mem_to_reg = mem_to_reg_q;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a slot-level model.
module tb_id_ex_stage;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 i_clk = ~i_clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave));

    // one instruction slot as the EX stage should currently see it
    typedef struct packed {
        logic        valid;
        logic [31:0] rs, rt, imm;
        logic        alu_src;
        logic [4:0]  rs_a, rt_a, rd, shamt;
        logic        ushamt;
        logic [3:0]  op;
        logic        rw, mr, mw, m2r;
    } slot_t;
    slot_t m;

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (bus.i_exmem_reg_write && bus.i_exmem_rd != 0 && bus.i_exmem_rd == a) return bus.i_exmem_result;
        if (bus.i_memwb_reg_write && bus.i_memwb_rd != 0 && bus.i_memwb_rd == a) return bus.i_memwb_data;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rtv;
        rtv = fwd(m.rt_a, m.rt);
        check({tag, ".valid"}, 32'(bus.o_valid), 32'(m.valid));
        check({tag, ".d1"}, bus.o_data_1, fwd(m.rs_a, m.rs));
        check({tag, ".d2"}, bus.o_data_2, m.alu_src ? m.imm : rtv);
        check({tag, ".st"}, bus.o_store_data, rtv);
        check({tag, ".shamt"}, 32'(bus.o_shamt), 32'(m.shamt));
        check({tag, ".ushamt"}, 32'(bus.o_ushamt), 32'(m.ushamt));
        check({tag, ".op"}, 32'(bus.o_operation), 32'(m.op));
        check({tag, ".rd"}, 32'(bus.o_rd), 32'(m.rd));
        check({tag, ".ctl"}, 32'({bus.o_reg_write, bus.o_mem_read, bus.o_mem_write, bus.o_mem_to_reg}),
              32'({m.rw, m.mr, m.mw, m.m2r}));
    endtask

    // one clock edge; the model follows flush > stall > load
    task automatic step();
        @(posedge i_clk);
        if (!i_rst_n) m = '0;
        else if (bus.i_flush) begin
            m = '0;
            m.op = 4'd2;
        end else if (!bus.i_stall) begin
            m.valid = bus.i_valid;   m.rs = bus.i_rs_data;  m.rt = bus.i_rt_data;
            m.imm = bus.i_sign_ext ? 32'($signed(bus.i_imm)) : 32'(bus.i_imm);
            m.alu_src = bus.i_alu_src;
            m.rs_a = bus.i_rs_addr;  m.rt_a = bus.i_rt_addr; m.rd = bus.i_rd_addr;
            m.shamt = bus.i_shamt;   m.ushamt = bus.i_ushamt; m.op = bus.i_operation;
            m.rw = bus.i_reg_write;  m.mr = bus.i_mem_read;
            m.mw = bus.i_mem_write;  m.m2r = bus.i_mem_to_reg;
        end
        #1;
    endtask

    task automatic load(input logic [4:0] rs_a, input logic [31:0] rs, input logic [4:0] rt_a,
                        input logic [31:0] rt, input logic [3:0] op);
        bus.i_valid = 1'b1; bus.i_rs_addr = rs_a; bus.i_rs_data = rs;
        bus.i_rt_addr = rt_a; bus.i_rt_data = rt; bus.i_operation = op;
    endtask

    task automatic no_fwd();
        bus.i_exmem_reg_write = 1'b0; bus.i_memwb_reg_write = 1'b0;
        bus.i_exmem_rd = '0; bus.i_memwb_rd = '0;
        bus.i_exmem_result = 32'hDEAD_0001; bus.i_memwb_data = 32'hDEAD_0002;
    endtask

    task automatic randomize_inputs();
        bus.i_stall = ($urandom_range(0, 4) == 0);
        bus.i_flush = ($urandom_range(0, 9) == 0);
        bus.i_valid = 1'($urandom);
        bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
        bus.i_imm = 16'($urandom); bus.i_sign_ext = 1'($urandom);
        bus.i_alu_src = 1'($urandom);
        bus.i_rs_addr = 5'($urandom_range(0, 3)); bus.i_rt_addr = 5'($urandom_range(0, 3));
        bus.i_rd_addr = 5'($urandom); bus.i_shamt = 5'($urandom);
        bus.i_ushamt = 1'($urandom); bus.i_operation = 4'($urandom);
        {bus.i_reg_write, bus.i_mem_read, bus.i_mem_write, bus.i_mem_to_reg} = 4'($urandom);
        bus.i_exmem_reg_write = 1'($urandom); bus.i_exmem_rd = 5'($urandom_range(0, 3));
        bus.i_exmem_result = $urandom;
        bus.i_memwb_reg_write = 1'($urandom); bus.i_memwb_rd = 5'($urandom_range(0, 3));
        bus.i_memwb_data = $urandom;
    endtask

    initial begin
        m = '0;
        // reset held with live, nonzero decode inputs
        bus.i_stall = 1'b0; bus.i_flush = 1'b0;
        load(5'd1, 32'h1234, 5'd2, 32'h5678, 4'd7);
        bus.i_imm = 16'h8000; bus.i_sign_ext = 1'b1; bus.i_alu_src = 1'b1;
        bus.i_rd_addr = 5'd9; bus.i_shamt = 5'd3; bus.i_ushamt = 1'b1;
        {bus.i_reg_write, bus.i_mem_read, bus.i_mem_write, bus.i_mem_to_reg} = 4'hF;
        no_fwd();
        #2 check_all("rst0");
        step();
        check_all("rst1");

        // release, then first edge loads normally
        i_rst_n = 1'b1;
        load(5'd1, 32'd5, 5'd2, 32'd7, 4'd2);
        bus.i_alu_src = 1'b0; bus.i_imm = 16'h0;
        step();
        check("first.d1", bus.o_data_1, 32'd5);
        check("first.d2", bus.o_data_2, 32'd7);
        check_all("first");

        // immediate extension
        bus.i_imm = 16'hFFFC; bus.i_sign_ext = 1'b1; bus.i_alu_src = 1'b1; bus.i_rt_data = 32'h77;
        step();
        check("imm.sext", bus.o_data_2, 32'hFFFF_FFFC);
        check("imm.st", bus.o_store_data, 32'h77);
        bus.i_sign_ext = 1'b0;
        step();
        check("imm.zext", bus.o_data_2, 32'h0000_FFFC);
        check_all("imm");

        // forwarding priority
        bus.i_alu_src = 1'b0;
        load(5'd3, 32'h11, 5'd4, 32'h22, 4'd2);
        step();
        bus.i_exmem_reg_write = 1'b1; bus.i_exmem_rd = 5'd3; bus.i_exmem_result = 32'hAA;
        bus.i_memwb_reg_write = 1'b1; bus.i_memwb_rd = 5'd3; bus.i_memwb_data = 32'hBB;
        #1 check("fwd.exmem", bus.o_data_1, 32'hAA);
        bus.i_exmem_reg_write = 1'b0;
        #1 check("fwd.memwb", bus.o_data_1, 32'hBB);
        check_all("fwd");
        load(5'd0, 32'h33, 5'd0, 32'h44, 4'd2);
        bus.i_exmem_reg_write = 1'b1; bus.i_exmem_rd = 5'd0; bus.i_memwb_rd = 5'd0;
        step();
        check("fwd.r0", bus.o_data_1, 32'h33);
        check_all("fwd.r0");
        no_fwd();

        // stall holds SLL/4 for three edges
        load(5'd5, 32'h100, 5'd6, 32'h200, 4'd3);
        bus.i_shamt = 5'd4; bus.i_ushamt = 1'b1;
        step();
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load(5'd7, 32'h900 + i, 5'd8, 32'hA00, 4'd9);
            bus.i_shamt = 5'd17; bus.i_ushamt = 1'b0;
            step();
            check("stall.op", 32'(bus.o_operation), 32'd3);
            check("stall.shamt", 32'(bus.o_shamt), 32'd4);
        end
        bus.i_stall = 1'b0;
        step();
        check("unstall.op", 32'(bus.o_operation), 32'd9);
        check_all("unstall");

        // flush beats stall
        bus.i_flush = 1'b1; bus.i_stall = 1'b1;
        bus.i_reg_write = 1'b1; bus.i_mem_write = 1'b1;
        step();
        check("flush.valid", 32'(bus.o_valid), 32'd0);
        check("flush.rw", 32'(bus.o_reg_write), 32'd0);
        check("flush.mw", 32'(bus.o_mem_write), 32'd0);
        check("flush.op", 32'(bus.o_operation), 32'd2);
        check_all("flush");
        bus.i_flush = 1'b0; bus.i_stall = 1'b0;

        // async reset between edges
        load(5'd2, 32'hCAFE, 5'd3, 32'hBEEF, 4'd6);
        step();
        check("pre_arst.valid", 32'(bus.o_valid), 32'd1);
        #2 i_rst_n = 1'b0;
        m = '0;
        #1 check_all("arst");
        check("arst.d1", bus.o_data_1, 32'd0);
        #1 i_rst_n = 1'b1;
        step();
        check_all("post_arst");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS core.
- Captures decoded fields and register-file reads on each clock.
- Applies EX/MEM and MEM/WB forwarding and immediate selection, then drives operands, shamt, UShamt select and the 4-bit operation code into the ALU.
- Supports hazard-unit stall (hold) and branch flush (bubble).

Parameters:
- NBITS, 32, datapath width
- RNBITS, 5, register-address and shamt width
- NB_OP, 4, ALU operation code width
- NB_IMM, 16, immediate width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold all stage registers
- i_flush  in  1  load a bubble
- i_valid  in  1  decode slot holds a real instruction
- i_rs_data, i_rt_data  in  NBITS  register-file read data
- i_imm  in  NB_IMM  instruction immediate
- i_sign_ext  in  1  1 = sign-extend imm, 0 = zero-extend
- i_alu_src  in  1  1 = operand 2 is imm, 0 = rt
- i_rs_addr, i_rt_addr, i_rd_addr  in  RNBITS  source/dest register numbers
- i_shamt  in  RNBITS  shift amount field
- i_ushamt  in  1  shift uses shamt field
- i_operation  in  NB_OP  ALU operation code
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1  control bits
- i_exmem_reg_write  in  1  EX/MEM writes a register
- i_exmem_rd  in  RNBITS  EX/MEM destination
- i_exmem_result  in  NBITS  EX/MEM ALU result
- i_memwb_reg_write  in  1  MEM/WB writes a register
- i_memwb_rd  in  RNBITS  MEM/WB destination
- i_memwb_data  in  NBITS  MEM/WB writeback data
- o_valid  out  1  EX slot valid
- o_data_1, o_data_2  out  NBITS  ALU operands
- o_store_data  out  NBITS  forwarded rt, for SW
- o_shamt  out  RNBITS  ALU shamt
- o_ushamt  out  1  ALU UShamt select
- o_operation  out  NB_OP  ALU operation
- o_rd  out  RNBITS  destination register
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1  registered control bits

Behaviour:
- Reset (i_rst_n=0, asynchronous): all registered fields are 0.
  - o_operation = 4'b0000 (AND).
  - o_valid = 0; all controls = 0.
  - Outputs read 0 while no forwarding match is present.
- Registered fields: valid, rs/rt data, extended imm, alu_src, rs/rt/rd addresses, shamt, ushamt, operation, control bits.
  - Latency is 1 cycle: a value presented at edge N is visible after edge N.
- Priority per rising edge is flush > stall > load.
  - Flush: valid, reg_write, mem_read, mem_write and mem_to_reg go to 0; operation goes to ADD (4'b0010); data, imm and addresses go to 0.
  - Stall without flush: every register holds its value.
  - Otherwise: load the inputs.
- Immediate extension happens before the register: sign_ext=1 replicates imm[15]; 0 fills with zeros. Example: 16'h8000 becomes 32'hFFFF8000 or 32'h00008000.
- Forwarding is combinational from the registered addresses, with the same rule for rs and rt:
  - If exmem_reg_write and exmem_rd != 0 and exmem_rd == addr, use i_exmem_result.
  - Else if memwb_reg_write and memwb_rd != 0 and memwb_rd == addr, use i_memwb_data.
  - Else use the registered data.
  - EX/MEM wins when both stages match.
  - Register 0 is never forwarded and always reads the registered value.
- Operand outputs:
  - o_data_1 = forwarded rs.
  - o_data_2 = extended imm if alu_src, else forwarded rt.
  - o_store_data = forwarded rt always, regardless of alu_src.
- o_shamt, o_ushamt and o_operation pass through from their registers.
- o_valid=0 does not gate the forwarding inputs. Downstream ignores the slot through the zeroed control bits.
- Reset asserted mid-stall or mid-flush clears the stage immediately. The first edge after release loads normally.

Test Plan:
- Reset: hold i_rst_n=0 with nonzero inputs, then release. All outputs are 0 before the first edge; after one edge with rs=5, rt=7, op=ADD, alu_src=0, o_data_1=5 and o_data_2=7.
- Immediate: imm=16'hFFFC, sign_ext=1, alu_src=1 gives o_data_2=32'hFFFFFFFC; sign_ext=0 gives 32'h0000FFFC; o_store_data equals rt.
- Forwarding priority: rs_addr=3, exmem_rd=3 with result 0xAA, memwb_rd=3 with data 0xBB, both writing, gives o_data_1=0xAA. Dropping exmem_reg_write gives 0xBB. With rs_addr=0 and both rd=0, o_data_1 equals the registered value.
- Stall: load op=SLL, shamt=4, then assert i_stall for 3 cycles with different inputs. Outputs stay SLL/4 throughout, and the new instruction loads on the first edge after release.
- Flush vs stall: assert i_flush and i_stall together with reg_write=1. After the edge, o_valid=0, o_reg_write=0, o_mem_write=0 and o_operation=4'b0010.
- Async reset mid-stream: pulse i_rst_n low between edges while the stage holds a valid instruction. Outputs clear without waiting for a clock edge.
